// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, width helpers and constants for the direct-mapped icache
package icache_pkg;
  typedef enum logic [1:0] {INIT, IDLE, REFILL, DONE} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int tag_w(input int sets, input int line_words);
    return 30 - $clog2(sets) - $clog2(line_words);
  endfunction
endpackage

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: beat counter, in-line address generator and word-serial memory handshake
module icache_refill_ctrl #(
  parameter int WORD_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [31:0]       i_base,
  input  logic              i_ack,
  output logic              o_req,
  output logic [31:0]       o_addr,
  output logic [WORD_W-1:0] o_beat,
  output logic              o_wr,
  output logic              o_last
);
  logic              r_req;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_beat;
  assign o_req  = r_req;
  assign o_addr = r_addr;
  assign o_beat = r_beat;
  assign o_wr   = r_req & i_ack;
  assign o_last = o_wr & (&r_beat);
  // launch a line fetch, then step the word address within the line on every accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_beat <= '0;
    end else if (i_start) begin
      r_req  <= 1'b1;
      r_addr <= i_base;
      r_beat <= '0;
    end else if (o_wr) begin
      r_req                <= ~&r_beat;
      r_beat               <= r_beat + 1'b1;
      r_addr[2 +: WORD_W]  <= r_beat + 1'b1;
    end
  end
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with word-serial line refill
module icache_dm
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc_i,
  input  logic        if_valid_req_i,
  input  logic        if_jump_stop_Icache_i,
  output logic [31:0] Icache_inst_o,
  output logic [31:0] Icache_inst_pc_o,
  output logic        Icache_inst_valid_o,
  output logic        Icache_stall_flag_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int IDX_W  = idx_w(SETS);
  localparam int WORD_W = word_w(LINE_WORDS);
  localparam int TAG_W  = tag_w(SETS, LINE_WORDS);
  state_t            r_state;
  logic [31:0]       r_data [SETS][LINE_WORDS];
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [SETS-1:0]   r_valid;
  logic [31:0]       r_pc, r_inst, r_inst_pc;
  logic              r_inst_valid, r_cancel;
  logic [IDX_W-1:0]  w_idx, w_ridx;
  logic [WORD_W-1:0] w_word, w_rword, w_beat;
  logic [TAG_W-1:0]  w_tag, w_rtag;
  logic              w_hit, w_start, w_wr, w_last;
  logic [31:0]       w_base;
  assign w_idx   = if_pc_i[2+WORD_W +: IDX_W];
  assign w_word  = if_pc_i[2 +: WORD_W];
  assign w_tag   = if_pc_i[31 -: TAG_W];
  assign w_ridx  = r_pc[2+WORD_W +: IDX_W];
  assign w_rword = r_pc[2 +: WORD_W];
  assign w_rtag  = r_pc[31 -: TAG_W];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_start = (r_state == IDLE) && if_valid_req_i && !w_hit;
  assign w_base  = {if_pc_i[31:2+WORD_W], {(WORD_W+2){1'b0}}};
  assign Icache_inst_o       = r_inst;
  assign Icache_inst_pc_o    = r_inst_pc;
  assign Icache_inst_valid_o = r_inst_valid;
  assign Icache_stall_flag_o = (r_state != IDLE);
  icache_refill_ctrl #(.WORD_W(WORD_W)) u_refill (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_base (w_base),
    .i_ack  (mem_ack_i),
    .o_req  (mem_req_o),
    .o_addr (mem_addr_o),
    .o_beat (w_beat),
    .o_wr   (w_wr),
    .o_last (w_last)
  );
  // lookup / refill sequencing; a redirect during refill only suppresses delivery, never the install
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT;
      r_valid      <= '0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_cancel     <= 1'b0;
      r_pc         <= '0;
    end else begin
      r_cancel <= (r_state == REFILL) && (r_cancel || if_jump_stop_Icache_i);
      case (r_state)
        INIT: begin
          r_inst_valid <= 1'b0;
          r_state      <= IDLE;
        end
        IDLE: begin
          r_inst_valid <= if_valid_req_i && w_hit;
          if (if_valid_req_i && w_hit) begin
            r_inst    <= r_data[w_idx][w_word];
            r_inst_pc <= if_pc_i;
          end
          if (w_start) begin
            r_pc    <= if_pc_i;
            r_state <= REFILL;
          end
        end
        REFILL: begin
          r_inst_valid <= 1'b0;
          if (w_last) begin
            r_valid[w_ridx] <= 1'b1;
            r_state         <= DONE;
          end
        end
        DONE: begin
          r_inst       <= r_data[w_ridx][w_rword];
          r_inst_pc    <= r_pc;
          r_inst_valid <= !(r_cancel || if_jump_stop_Icache_i);
          r_state      <= IDLE;
        end
        default: r_state <= INIT;
      endcase
    end
  end
  // line data and tag storage; contents are meaningful only under the valid bits
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_data[w_ridx][w_beat] <= mem_rdata_i;
      if (w_last) r_tag[w_ridx] <= w_rtag;
    end
  end
endmodule
